// File: rtl/onehot_pkg.sv
// rtl/onehot_pkg.sv - shared types and elaboration helpers for the one-hot decoder pipe
package onehot_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

    function automatic int tree_pow(input int base, input int exp);
        int r;
        r = 1;
        for (int i = 0; i < exp; i++) begin
            r = r * base;
        end
        return r;
    endfunction

    // Smallest number of radix-split levels whose leaf count covers width.
    function automatic int tree_levels(input int width, input int split);
        int l;
        int span;
        l = 0;
        span = 1;
        while (span < width) begin
            span = span * split;
            l = l + 1;
        end
        return l;
    endfunction

endpackage

// File: rtl/onehot_decoder_tree.sv
// rtl/onehot_decoder_tree.sv - combinational SPLIT-ary tree decoding a binary index to one-hot
module onehot_decoder_tree
    import onehot_pkg::*;
#(
    parameter  int WIDTH     = 16,
    parameter  int SPLIT     = 4,
    localparam int WIDTH_LOG = $clog2(WIDTH)
) (
    input  logic [WIDTH_LOG-1:0] enc_idx,
    output logic [WIDTH-1:0]     dec_vld
);

    localparam int LEVELS = tree_levels(WIDTH, SPLIT);

    logic [31:0] idx_ext;
    assign idx_ext = 32'(enc_idx);

    // Each node owns a contiguous index range; nodes starting at or past WIDTH
    // are never built, so out-of-range indices light no leaf.
    for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
        localparam int SPAN  = tree_pow(SPLIT, LEVELS - l);
        localparam int NODES = (WIDTH + SPAN - 1) / SPAN;
        logic [NODES-1:0] en;
        for (genvar j = 0; j < NODES; j++) begin : g_node
            logic parent;
            logic lo_ok;
            if (l == 1) begin : g_root
                assign parent = 1'b1;
            end else begin : g_child
                assign parent = g_lvl[l-1].en[j / SPLIT];
            end
            if (j == 0) begin : g_lo0
                assign lo_ok = 1'b1;
            end else begin : g_lo
                assign lo_ok = idx_ext >= 32'(j * SPAN);
            end
            assign en[j] = parent && lo_ok && (idx_ext < 32'((j + 1) * SPAN));
        end
    end

    assign dec_vld = g_lvl[LEVELS].en;

endmodule

// File: rtl/onehot_decoder_pipe.sv
// rtl/onehot_decoder_pipe.sv - one-hot decoder with 2-entry output buffer; ONEHOT_DECODER_RANGE_CHECK_EN enables dec_err
module onehot_decoder_pipe
    import onehot_pkg::*;
#(
    parameter  int WIDTH     = 16,
    parameter  int SPLIT     = 4,
    localparam int WIDTH_LOG = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_vld,
    output logic                 in_rdy,
    input  logic [WIDTH_LOG-1:0] enc_idx,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [WIDTH-1:0]     dec_vld,
    output logic                 dec_err
);

    buf_state_t       state;
    buf_state_t       state_nxt;
    logic [WIDTH-1:0] dec_new;
    logic [WIDTH-1:0] head_dec;
    logic [WIDTH-1:0] tail_dec;
    logic             push;
    logic             pop;
    logic             load_head;

    onehot_decoder_tree #(
        .WIDTH (WIDTH),
        .SPLIT (SPLIT)
    ) u_tree (
        .enc_idx (enc_idx),
        .dec_vld (dec_new)
    );

    assign out_vld = (state != EMPTY);
    assign push    = in_vld && in_rdy;
    assign pop     = out_vld && out_rdy;
    // New word goes to the head when the head slot is free or being vacated.
    assign load_head = (state == EMPTY) || (state == HALF && pop);

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (push) state_nxt = HALF;
            HALF: begin
                if (push && !pop)      state_nxt = FULL;
                else if (!push && pop) state_nxt = EMPTY;
            end
            FULL:    if (pop) state_nxt = HALF;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            in_rdy   <= 1'b0;
            head_dec <= '0;
            tail_dec <= '0;
        end else begin
            state  <= state_nxt;
            in_rdy <= (state_nxt != FULL);
            if (pop) head_dec <= tail_dec;
            if (push) begin
                if (load_head) head_dec <= dec_new;
                else           tail_dec <= dec_new;
            end
        end
    end

    assign dec_vld = out_vld ? head_dec : '0;

`ifdef ONEHOT_DECODER_RANGE_CHECK_EN
    logic err_new;
    logic head_err;
    logic tail_err;

    assign err_new = 32'(enc_idx) >= 32'(WIDTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_err <= 1'b0;
            tail_err <= 1'b0;
        end else begin
            if (pop) head_err <= tail_err;
            if (push) begin
                if (load_head) head_err <= err_new;
                else           tail_err <= err_new;
            end
        end
    end

    assign dec_err = out_vld && head_err;
`else
    assign dec_err = 1'b0;
`endif

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// tb/tb_onehot_decoder_pipe.sv - directed bench for onehot_decoder_pipe (WIDTH=16 and WIDTH=12 instances)
module tb_onehot_decoder_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_vld;
    logic        in_rdy;
    logic [3:0]  enc_idx;
    logic        out_vld;
    logic        out_rdy;
    logic [15:0] dec_vld;
    logic        dec_err;

    logic        in_vld_b;
    logic        in_rdy_b;
    logic [3:0]  enc_idx_b;
    logic        out_vld_b;
    logic        out_rdy_b;
    logic [11:0] dec_vld_b;
    logic        dec_err_b;

    int checks;
    int errors;

    onehot_decoder_pipe #(.WIDTH(16), .SPLIT(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .enc_idx (enc_idx),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .dec_vld (dec_vld),
        .dec_err (dec_err)
    );

    onehot_decoder_pipe #(.WIDTH(12), .SPLIT(4)) dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (in_vld_b),
        .in_rdy  (in_rdy_b),
        .enc_idx (enc_idx_b),
        .out_vld (out_vld_b),
        .out_rdy (out_rdy_b),
        .dec_vld (dec_vld_b),
        .dec_err (dec_err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_main(input string name, input logic exp_ov, input logic exp_ir,
                              input logic [15:0] exp_dec);
        checks++;
        if (out_vld !== exp_ov || in_rdy !== exp_ir || dec_vld !== exp_dec) begin
            errors++;
            $display("FAIL %s: out_vld=%b in_rdy=%b dec_vld=%h, expected out_vld=%b in_rdy=%b dec_vld=%h",
                     name, out_vld, in_rdy, dec_vld, exp_ov, exp_ir, exp_dec);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_vld = 1'b0; enc_idx = 4'd0; out_rdy = 1'b0;
        in_vld_b = 1'b0; enc_idx_b = 4'd0; out_rdy_b = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_main("reset_held", 1'b0, 1'b0, 16'h0000);
        checks++;
        if (dec_err !== 1'b0 || out_vld_b !== 1'b0 || in_rdy_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_misc: dec_err=%b out_vld_b=%b in_rdy_b=%b, expected 0 0 0",
                     dec_err, out_vld_b, in_rdy_b);
        end
        rst_n = 1'b1;
        #1;
        check_main("reset_release_before_edge", 1'b0, 1'b0, 16'h0000);
        tick();
        check_main("reset_first_edge", 1'b0, 1'b1, 16'h0000);
    endtask

    task automatic test_sweep();
        logic [15:0] exp;
        out_rdy = 1'b1;
        in_vld  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            enc_idx = 4'(i);
            tick();
            exp = 16'h0001 << i;
            check_main($sformatf("sweep_%0d", i), 1'b1, 1'b1, exp);
        end
        in_vld = 1'b0;
        tick();
        check_main("sweep_drain", 1'b0, 1'b1, 16'h0000);
    endtask

    task automatic test_backpressure();
        out_rdy = 1'b0;
        in_vld  = 1'b1;
        enc_idx = 4'd3;
        tick();
        check_main("bp_half", 1'b1, 1'b1, 16'h0008);
        enc_idx = 4'd7;
        tick();
        check_main("bp_full", 1'b1, 1'b0, 16'h0008);
        enc_idx = 4'd5;
        tick();
        check_main("bp_full_hold", 1'b1, 1'b0, 16'h0008);
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        @(negedge clk);
        check_main("bp_before_pop", 1'b1, 1'b0, 16'h0008);
        tick();
        check_main("bp_second_word", 1'b1, 1'b1, 16'h0080);
        tick();
        check_main("bp_empty", 1'b0, 1'b1, 16'h0000);
    endtask

    task automatic test_simultaneous();
        out_rdy = 1'b0;
        in_vld  = 1'b1;
        enc_idx = 4'd2;
        tick();
        check_main("sim_half", 1'b1, 1'b1, 16'h0004);
        out_rdy = 1'b1;
        enc_idx = 4'd9;
        tick();
        check_main("sim_swap1", 1'b1, 1'b1, 16'h0200);
        enc_idx = 4'd11;
        tick();
        check_main("sim_swap2", 1'b1, 1'b1, 16'h0800);
        in_vld = 1'b0;
        tick();
        check_main("sim_drain", 1'b0, 1'b1, 16'h0000);
    endtask

    task automatic test_range();
        logic exp_err;
`ifdef ONEHOT_DECODER_RANGE_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        out_rdy_b = 1'b0;
        in_vld_b  = 1'b1;
        enc_idx_b = 4'd13;
        tick();
        checks++;
        if (out_vld_b !== 1'b1 || dec_vld_b !== 12'h000 || dec_err_b !== exp_err) begin
            errors++;
            $display("FAIL range_13: out_vld=%b dec_vld=%h dec_err=%b, expected 1 000 %b",
                     out_vld_b, dec_vld_b, dec_err_b, exp_err);
        end
        enc_idx_b = 4'd11;
        tick();
        in_vld_b  = 1'b0;
        out_rdy_b = 1'b1;
        tick();
        checks++;
        if (out_vld_b !== 1'b1 || dec_vld_b !== 12'h800 || dec_err_b !== 1'b0) begin
            errors++;
            $display("FAIL range_11: out_vld=%b dec_vld=%h dec_err=%b, expected 1 800 0",
                     out_vld_b, dec_vld_b, dec_err_b);
        end
        tick();
        checks++;
        if (out_vld_b !== 1'b0 || dec_vld_b !== 12'h000 || dec_err_b !== 1'b0) begin
            errors++;
            $display("FAIL range_drain: out_vld=%b dec_vld=%h dec_err=%b, expected 0 000 0",
                     out_vld_b, dec_vld_b, dec_err_b);
        end
        out_rdy_b = 1'b0;
    endtask

    task automatic test_mid_reset();
        out_rdy = 1'b0;
        in_vld  = 1'b1;
        enc_idx = 4'd1;
        tick();
        enc_idx = 4'd4;
        tick();
        check_main("mr_full", 1'b1, 1'b0, 16'h0002);
        in_vld = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_main("mr_async", 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        rst_n   = 1'b1;
        out_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_main($sformatf("mr_after_%0d", k), 1'b0, 1'b1, 16'h0000);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_sweep();
        test_backpressure();
        test_simultaneous();
        test_range();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/onehot_decoder_pipe.md
ONEHOT_DECODER_PIPE -- requirements
Module: onehot_decoder_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16: one-hot output width, range 2..1024, need not be a power of two.
REQ-002 SHALL have parameter SPLIT, default 4: decoder tree radix, range 2..WIDTH.
REQ-003 SHALL derive localparam WIDTH_LOG = $clog2(WIDTH) as the index width.
REQ-004 SHALL have port clk  input  1  sole clock; all flops on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port in_vld  input  1  index valid.
REQ-007 SHALL have port in_rdy  output  1  block can accept an index.
REQ-008 SHALL have port enc_idx  input  WIDTH_LOG  binary index to decode.
REQ-009 SHALL have port out_vld  output  1  decoded word valid.
REQ-010 SHALL have port out_rdy  input  1  consumer accepts the decoded word.
REQ-011 SHALL have port dec_vld  output  WIDTH  one-hot decoded word.
REQ-012 SHALL have port dec_err  output  1  current output came from an out-of-range index.

Function
REQ-013 SHALL transfer input when in_vld && in_rdy are both high at a rising clk edge, and output when out_vld && out_rdy are both high.
REQ-014 SHALL buffer decoded words in a 2-entry in-order buffer: states EMPTY (0), HALF (1), FULL (2).
REQ-015 SHALL make transitions as follows: input-only transfer increments the count; output-only transfer decrements it; simultaneous transfers leave it unchanged.
REQ-016 SHALL drive in_rdy from a flop, high exactly when the state is not FULL; in FULL, in_rdy SHALL go high the cycle after an output transfer.
REQ-017 SHALL have out_vld high exactly when the state is not EMPTY; out_vld SHALL be combinational from state flops only.
REQ-018 SHALL give a latency of 1 cycle: an index accepted at edge N appears on dec_vld after edge N when the buffer was EMPTY or drained simultaneously.
REQ-019 SHALL sustain full throughput of one word per cycle while out_rdy is held high.
REQ-020 SHALL decode a valid index as dec_vld[i]=1 for i==enc_idx, with all other bits 0.
REQ-021 SHALL present dec_vld, dec_err as all-zero when out_vld is low.
REQ-022 SHALL hold dec_vld and dec_err stable while out_vld && !out_rdy.
REQ-023 SHALL ignore enc_idx when in_vld is low, and when in_vld is high but in_rdy is low.
REQ-024 SHALL not require in_vld to stay asserted, and SHALL not let out_rdy depend combinationally on out_vld.

Reset
REQ-025 SHALL, while rst_n is low, force state EMPTY, in_rdy=0, out_vld=0, dec_vld=0, dec_err=0.
REQ-026 SHALL raise in_rdy on the first rising clk edge after rst_n deasserts.
REQ-027 SHALL discard buffered words when reset asserts mid-operation; no partial word SHALL be emitted afterwards.

Configuration
REQ-028 SHALL use macro ONEHOT_DECODER_RANGE_CHECK_EN for the out-of-range check; it changes no other behaviour or port.
REQ-029 SHALL, with the macro defined, on an accepted enc_idx >= WIDTH store dec_vld=0 and dec_err=1, passed in order like any word.
REQ-030 SHALL, without the macro, produce dec_vld=0 for enc_idx >= WIDTH and tie dec_err to 0, with no check logic synthesized.

Structure
REQ-031 SHALL declare in shared package onehot_pkg the 2-bit buffer state enum (EMPTY, HALF, FULL).
REQ-032 SHALL instantiate the combinational decode, located before the buffer, as sub-module onehot_decoder_tree (WIDTH, SPLIT, enc_idx -> dec_vld), built as a SPLIT-ary tree.

Verification (WIDTH=16, SPLIT=4)
REQ-033 SHALL check reset: rst_n low -> in_rdy=0, out_vld=0, dec_vld=16'h0000; first edge after release -> in_rdy=1.
REQ-034 SHALL check sweep: enc_idx 0..15 with out_rdy=1 -> dec_vld 16'h0001..16'h8000, one per cycle, 1-cycle latency, no bubbles.
REQ-035 SHALL check backpressure: out_rdy=0, send 3 and 7 -> FULL, in_rdy=0, dec_vld=16'h0008 held; out_rdy=1 -> 16'h0008 then 16'h0080, in_rdy=1 one cycle after the first output transfer.
REQ-036 SHALL check simultaneous transfer: in HALF with out_rdy=1 and in_vld=1 -> state stays HALF, order preserved.
REQ-037 SHALL check range: WIDTH=12 and enc_idx=13 -> with macro, dec_vld=0 and dec_err=1; without macro, dec_vld=0 and dec_err=0.
REQ-038 SHALL check mid-reset: FULL, assert rst_n low -> out_vld=0 immediately; after release, no stale word appears.
